// File: rtl/memory_range_printer.sv
// memory_range_printer: walks CHANNELS wide memory buses slot by slot inside a
// captured channel mask / slot window and emits one fixed-format frame per
// printed slot to the UART writer over a start/end handshake.
module memory_range_printer #(
    parameter int          UART_BUS_SIZE        = 8,
    parameter int          MEMORY_SLOT_SIZE     = 32,
    parameter int          MEMORY_DATA_BUS_SIZE = 1024,
    parameter int          CHANNELS             = 2,
    parameter logic [7:0]  PREFIX               = 8'h4D,
    parameter int          DATA_OUT_BUS_SIZE    = 8 + 2*UART_BUS_SIZE + MEMORY_SLOT_SIZE,
    localparam int         SLOTS                = MEMORY_DATA_BUS_SIZE / MEMORY_SLOT_SIZE,
    localparam int         SLOT_W               = $clog2(SLOTS),
    localparam int         CH_IDX_W             = $clog2(CHANNELS),
    localparam int         CH_W                 = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                                 i_clk,
    input  logic                                 i_reset,
    input  logic                                 i_start,
    input  logic                                 i_abort,
    input  logic                                 i_wr_end,
    input  logic                                 i_skip_zero,
    input  logic [CHANNELS-1:0]                  i_channel_mask,
    input  logic [SLOT_W-1:0]                    i_first_slot,
    input  logic [SLOT_W-1:0]                    i_last_slot,
    input  logic [CHANNELS*MEMORY_DATA_BUS_SIZE-1:0] i_memory_content,
    input  logic [UART_BUS_SIZE-1:0]             i_clk_cicle,
    output logic                                 o_start_wr,
    output logic [DATA_OUT_BUS_SIZE-1:0]         o_data_wr,
    output logic                                 o_busy,
    output logic                                 o_end,
    output logic                                 o_aborted,
    output logic [15:0]                          o_frame_count
);

    // Channel and slot index must fit in the frame's index field.
    if (CH_IDX_W + SLOT_W > UART_BUS_SIZE) begin : g_index_too_wide
        $error("memory_range_printer: channel+slot index does not fit UART_BUS_SIZE");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_GAP,
        S_WAIT_WR,
        S_DONE
    } state_t;

    state_t                         r_state;
    state_t                         w_next_state;

    logic [CH_W-1:0]                r_ch;
    logic [SLOT_W-1:0]              r_slot;
    logic [CHANNELS-1:0]            r_mask;
    logic [SLOT_W-1:0]              r_first;
    logic [SLOT_W-1:0]              r_last;
    logic                           r_skip;
    logic                           r_last_printed;
    logic [DATA_OUT_BUS_SIZE-1:0]   r_data;
    logic                           r_start_wr;
    logic                           r_end;
    logic                           r_aborted;
    logic [15:0]                    r_count;

    logic [MEMORY_SLOT_SIZE-1:0]    w_slots [CHANNELS][SLOTS];
    logic [MEMORY_SLOT_SIZE-1:0]    w_cand_data;
    logic [UART_BUS_SIZE-1:0]       w_index;
    logic [DATA_OUT_BUS_SIZE-1:0]   w_frame;
    logic                           w_print;
    logic                           w_last_cand;
    logic                           w_start_empty;
    logic                           w_start_ok;
    logic                           w_abort_ok;

    // Split every channel bus into its slots so the candidate is a plain 2-D lookup.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        for (genvar s = 0; s < SLOTS; s++) begin : g_slot
            assign w_slots[c][s] =
                i_memory_content[c*MEMORY_DATA_BUS_SIZE + s*MEMORY_SLOT_SIZE +: MEMORY_SLOT_SIZE];
        end
    end

    // Candidate evaluation: live memory/cycle data, captured mask/window/skip.
    always_comb begin
        w_cand_data   = w_slots[r_ch][r_slot];
        w_index       = UART_BUS_SIZE'({r_ch, r_slot});
        w_frame       = {PREFIX, i_clk_cicle, w_index, w_cand_data};
        w_print       = r_mask[r_ch] && !(r_skip && (w_cand_data == '0));
        w_last_cand   = (r_ch == CH_W'(CHANNELS - 1)) && (r_slot == r_last);
        w_start_empty = (i_first_slot > i_last_slot) || (i_channel_mask == '0);
        w_start_ok    = (r_state == S_IDLE) && i_start;
        w_abort_ok    = (r_state != S_IDLE) && i_abort;
    end

    // Next-state logic; abort overrides every other event outside IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (i_start) w_next_state = w_start_empty ? S_DONE : S_SCAN;
            S_SCAN:    if (w_print)          w_next_state = S_GAP;
                       else if (w_last_cand) w_next_state = S_DONE;
            S_GAP:     w_next_state = S_WAIT_WR;
            S_WAIT_WR: if (i_wr_end) w_next_state = r_last_printed ? S_DONE : S_SCAN;
            S_DONE:    w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
        if (w_abort_ok) w_next_state = S_IDLE;
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next_state;
    end

    // Datapath: config capture, slot walk, frame register, status flags.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ch           <= '0;
            r_slot         <= '0;
            r_mask         <= '0;
            r_first        <= '0;
            r_last         <= '0;
            r_skip         <= 1'b0;
            r_last_printed <= 1'b0;
            r_data         <= '0;
            r_start_wr     <= 1'b0;
            r_end          <= 1'b0;
            r_aborted      <= 1'b0;
            r_count        <= '0;
        end else begin
            r_start_wr <= 1'b0;
            if (w_start_ok) begin
                r_mask         <= i_channel_mask;
                r_first        <= i_first_slot;
                r_last         <= i_last_slot;
                r_skip         <= i_skip_zero;
                r_ch           <= '0;
                r_slot         <= i_first_slot;
                r_last_printed <= 1'b0;
                r_count        <= '0;
                r_aborted      <= 1'b0;
                r_end          <= w_start_empty;
            end else if (w_abort_ok) begin
                r_end     <= 1'b1;
                r_aborted <= 1'b1;
            end else begin
                if (r_state == S_SCAN) begin
                    if (r_slot == r_last) begin
                        r_slot <= r_first;
                        r_ch   <= r_ch + 1'b1;
                    end else begin
                        r_slot <= r_slot + 1'b1;
                    end
                    if (w_print) begin
                        r_data         <= w_frame;
                        r_start_wr     <= 1'b1;
                        r_last_printed <= w_last_cand;
                        if (r_count != 16'hFFFF) r_count <= r_count + 16'd1;
                    end else if (w_last_cand) begin
                        r_end <= 1'b1;
                    end
                end
                if ((r_state == S_WAIT_WR) && i_wr_end && r_last_printed) r_end <= 1'b1;
            end
        end
    end

    assign o_start_wr    = r_start_wr;
    assign o_data_wr     = r_data;
    assign o_busy        = (r_state != S_IDLE);
    assign o_end         = r_end;
    assign o_aborted     = r_aborted;
    assign o_frame_count = r_count;

endmodule

// File: tb/tb_memory_range_printer.sv
// Scoreboard bench for memory_range_printer: a slot-list reference model fills
// the expected-frame queue at each start; a monitor pops on every o_start_wr.
module tb_memory_range_printer;

    localparam int CH = 2, SLOTS = 32, SW = 32, BUS = 1024;

    logic             clk = 1'b0;
    logic             i_reset, i_start, i_abort, i_wr_end, i_skip_zero;
    logic [CH-1:0]    i_channel_mask;
    logic [4:0]       i_first_slot, i_last_slot;
    logic [CH*BUS-1:0] mem;
    logic [7:0]       cycv;
    logic             o_start_wr, o_busy, o_end, o_aborted;
    logic [55:0]      o_data_wr;
    logic [15:0]      o_frame_count;

    logic [55:0] sb[$];
    logic [55:0] cap[$];
    int n_tests = 0, n_fail = 0;
    int cyc = 0, start_cyc = 0, last_pulse = 0, pulses = 0, exp_n = 0, done_cyc = 0;
    int wr_delay = 3, wr_cnt = 0;
    bit wr_cont = 0, chk_space = 0, chk_lat = 0;

    memory_range_printer #(.UART_BUS_SIZE(8), .MEMORY_SLOT_SIZE(32),
                           .MEMORY_DATA_BUS_SIZE(1024), .CHANNELS(2)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_abort(i_abort),
        .i_wr_end(i_wr_end), .i_skip_zero(i_skip_zero), .i_channel_mask(i_channel_mask),
        .i_first_slot(i_first_slot), .i_last_slot(i_last_slot),
        .i_memory_content(mem), .i_clk_cicle(cycv),
        .o_start_wr(o_start_wr), .o_data_wr(o_data_wr), .o_busy(o_busy),
        .o_end(o_end), .o_aborted(o_aborted), .o_frame_count(o_frame_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: list every (channel, slot) in the window, keep the printable ones.
    task automatic build_expected(input logic [CH-1:0] mask, input int first, input int last,
                                  input bit skip);
        logic [31:0] d;
        sb.delete(); cap.delete(); pulses = 0;
        if (first <= last)
            for (int c = 0; c < CH; c++)
                for (int s = first; s <= last; s++) begin
                    d = mem[c*BUS + s*SW +: SW];
                    if (mask[c] && !(skip && d == 32'h0))
                        sb.push_back({8'h4D, cycv, 8'(c*SLOTS + s), d});
                end
        exp_n = sb.size();
    endtask

    task automatic fill_mem(input int zero_pct);
        for (int i = 0; i < CH*SLOTS; i++)
            mem[i*SW +: SW] = ($urandom_range(0, 99) < zero_pct) ? 32'h0 : $urandom();
    endtask

    task automatic start_dump(input logic [CH-1:0] mask, input int first, input int last,
                              input bit skip);
        build_expected(mask, first, last, skip);
        i_channel_mask = mask;
        i_first_slot   = 5'(first);
        i_last_slot    = 5'(last);
        i_skip_zero    = skip;
        @(posedge clk); #1;
        i_start = 1'b1; start_cyc = cyc;
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (!(o_end && !o_busy) && t < 20000) begin
            @(posedge clk); #1; t++;
        end
        done_cyc = cyc;
        if (t >= 20000) begin
            n_tests++; n_fail++;
            $display("FAIL %s_timeout: actual=busy required=done", tag);
        end
        check({tag, "_leftover"}, sb.size(), 0);
        check({tag, "_pulses"},   pulses, exp_n);
        check({tag, "_count"},    o_frame_count, exp_n);
        check({tag, "_aborted"},  o_aborted, 0);
    endtask

    // Monitor: every frame pulse must match the head of the scoreboard.
    initial begin
        logic [55:0] e;
        forever begin
            @(negedge clk);
            if (!i_reset && o_start_wr) begin
                if (pulses == 0 && chk_lat) check("first_latency", cyc - start_cyc, 2);
                if (pulses > 0 && chk_space) check("pulse_spacing", cyc - last_pulse, 3);
                last_pulse = cyc;
                pulses++;
                cap.push_back(o_data_wr);
                if (sb.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_pulse: actual=%h required=none", o_data_wr);
                end else begin
                    e = sb.pop_front();
                    check("frame", o_data_wr, e);
                end
            end
        end
    end

    // UART writer model: i_wr_end wr_delay cycles after a pulse, or held high.
    initial begin
        i_wr_end = 1'b0;
        forever begin
            @(negedge clk);
            if (wr_cont) i_wr_end = 1'b1;
            else begin
                i_wr_end = 1'b0;
                if (o_start_wr) wr_cnt = wr_delay;
                else if (wr_cnt > 0) begin
                    wr_cnt--;
                    if (wr_cnt == 0) i_wr_end = 1'b1;
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        i_reset = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_skip_zero = 1'b0;
        i_channel_mask = '0; i_first_slot = '0; i_last_slot = '0;
        mem = '0; cycv = 8'h00;
        #12;
        check("rst_start_wr", o_start_wr, 0);
        check("rst_data",     o_data_wr, 0);
        check("rst_busy",     o_busy, 0);
        check("rst_end",      o_end, 0);
        check("rst_aborted",  o_aborted, 0);
        check("rst_count",    o_frame_count, 0);
        @(negedge clk); i_reset = 1'b0;

        // Full dump, both channels, writer answers 3 cycles after each pulse.
        fill_mem(10); cycv = 8'h11; chk_lat = 1;
        start_dump(2'b11, 0, 31, 0);
        wait_done("full");
        chk_lat = 0;
        check("full_end", o_end, 1);
        check("full_first_idx", cap.size() > 0  ? cap[0][39:32]  : 8'hFF, 8'h00);
        check("full_last_idx",  cap.size() > 63 ? cap[63][39:32] : 8'h00, 8'h3F);

        // Window on channel 1 only.
        fill_mem(0); mem[BUS + 5*SW +: SW] = 32'hDEADBEEF; cycv = 8'h2A;
        start_dump(2'b10, 4, 6, 0);
        wait_done("window");
        check("window_mid", cap.size() > 1 ? cap[1] : 56'h0, 56'h4D2A25DEADBEEF);

        // Skip-zero with only slots 3 and 17 non-zero on channel 0.
        fill_mem(0);
        for (int s = 0; s < SLOTS; s++) mem[s*SW +: SW] = 32'h0;
        mem[3*SW +: SW] = 32'h0000_0003; mem[17*SW +: SW] = 32'hA5A5_0011;
        start_dump(2'b01, 0, 31, 1);
        wait_done("skip");
        check("skip_idx0", cap.size() > 0 ? cap[0][39:32] : 8'hFF, 8'h03);
        check("skip_idx1", cap.size() > 1 ? cap[1][39:32] : 8'hFF, 8'h11);

        // Empty dumps: inverted window, then zero mask.
        start_dump(2'b11, 9, 2, 0);
        wait_done("empty_win");
        check("empty_win_time", done_cyc - start_cyc, 2);
        start_dump(2'b00, 0, 31, 0);
        wait_done("empty_mask");
        check("empty_mask_time", done_cyc - start_cyc, 2);

        // Abort while waiting on the writer after frame 5.
        fill_mem(0); wr_delay = 10;
        start_dump(2'b11, 0, 31, 0);
        t = 0;
        while (pulses < 5 && t < 2000) begin @(negedge clk); t++; end
        check("abort_reached5", pulses, 5);
        @(posedge clk); #1; i_abort = 1'b1;
        @(posedge clk); #1; i_abort = 1'b0;
        check("abort_busy",    o_busy, 0);
        check("abort_end",     o_end, 1);
        check("abort_flag",    o_aborted, 1);
        check("abort_count",   o_frame_count, 5);
        check("abort_data",    o_data_wr, cap.size() > 4 ? cap[4] : 56'h0);
        sb.delete();
        repeat (30) @(posedge clk);
        check("abort_no_more", pulses, 5);
        wr_delay = 3;
        start_dump(2'b01, 0, 3, 0);
        check("restart_end_clr",     o_end, 0);
        check("restart_aborted_clr", o_aborted, 0);
        wait_done("restart");

        // Writer end held high: ignored in GAP, pulses exactly 3 cycles apart.
        fill_mem(0); wr_cont = 1; chk_space = 1; chk_lat = 1;
        start_dump(2'b11, 0, 31, 0);
        wait_done("cont");
        wr_cont = 0; chk_space = 0; chk_lat = 0;

        // Randomized configurations.
        for (int k = 0; k < 8; k++) begin
            fill_mem(35); cycv = 8'($urandom());
            wr_delay = $urandom_range(1, 5);
            start_dump(2'($urandom_range(0, 3)), $urandom_range(0, 31), $urandom_range(0, 31),
                       1'($urandom_range(0, 1)));
            wait_done($sformatf("rand%0d", k));
        end
        wr_delay = 3;

        // Asynchronous reset in the middle of a dump.
        fill_mem(0);
        start_dump(2'b11, 0, 31, 0);
        t = 0;
        while (pulses < 3 && t < 2000) begin @(negedge clk); t++; end
        #2 i_reset = 1'b1;
        #1;
        check("arst_start_wr", o_start_wr, 0);
        check("arst_data",     o_data_wr, 0);
        check("arst_busy",     o_busy, 0);
        check("arst_end",      o_end, 0);
        check("arst_aborted",  o_aborted, 0);
        check("arst_count",    o_frame_count, 0);
        sb.delete(); wr_cnt = 0;
        @(negedge clk); i_reset = 1'b0;
        repeat (5) @(posedge clk); #1;
        check("arst_idle", o_busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_range_printer.md
Name: memory_range_printer

Overview:
- Multi-channel, range-limited successor to the debugger memory dump printer.
- Walks one or more wide memory buses slot by slot.
- Builds one fixed-format frame per printed slot and hands it to the UART writer over a start/end handshake.
- Adds channel masking, a first/last slot window, a skip-zero mode, abort, and a frame counter. Sits between the halted datapath memories and the debugger UART TX path.

Parameters:
- UART_BUS_SIZE, 8, width of the clock-cycle field and the index field.
- MEMORY_SLOT_SIZE, 32, bits per printed slot.
- MEMORY_DATA_BUS_SIZE, 1024, bits per channel bus; SLOTS = MEMORY_DATA_BUS_SIZE/MEMORY_SLOT_SIZE (32).
- CHANNELS, 2, number of memory buses.
- PREFIX, 8'h4D, frame prefix byte.
- DATA_OUT_BUS_SIZE, 8+2*UART_BUS_SIZE+MEMORY_SLOT_SIZE (56), frame width.
- Constraint: clog2(CHANNELS)+clog2(SLOTS) <= UART_BUS_SIZE (checked at elaboration).

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_start  in  1  begin dump (honoured in IDLE only).
- i_abort  in  1  stop dump.
- i_wr_end  in  1  UART writer finished current frame.
- i_skip_zero  in  1  do not print slots equal to zero.
- i_channel_mask  in  CHANNELS  channels to dump.
- i_first_slot  in  clog2(SLOTS)  first slot index.
- i_last_slot  in  clog2(SLOTS)  last slot index.
- i_memory_content  in  CHANNELS*MEMORY_DATA_BUS_SIZE  channel c at bits [c*MEMORY_DATA_BUS_SIZE +: MEMORY_DATA_BUS_SIZE].
- i_clk_cicle  in  UART_BUS_SIZE  current cycle count, copied into each frame.
- o_start_wr  out  1  one-cycle frame-valid pulse.
- o_data_wr  out  DATA_OUT_BUS_SIZE  frame.
- o_busy  out  1  high when not IDLE.
- o_end  out  1  level; set on completion or abort, cleared on the next accepted start.
- o_aborted  out  1  level; set on abort, cleared on the next accepted start.
- o_frame_count  out  16  frames sent in the current or last dump.

Behaviour:
- Reset: async. state=IDLE; all outputs 0; channel/slot pointers 0.
- Frame layout: {PREFIX, i_clk_cicle, index, slot_data}.
  - index = {zero pad, channel[clog2(CHANNELS)-1:0], slot[clog2(SLOTS)-1:0]}.
  - slot_data = i_memory_content[c*MEMORY_DATA_BUS_SIZE + s*MEMORY_SLOT_SIZE +: MEMORY_SLOT_SIZE].
  - Memory and cycle count are read live in the cycle the frame is built. Mask, window and skip_zero are captured at start.
- IDLE:
  - i_start: capture config; ch=0, slot=first; clear o_end, o_aborted, o_frame_count; go to SCAN.
- SCAN (one candidate per cycle):
  - Skip the candidate (no frame) if the channel is unmasked, or if skip_zero is set and the data is 0.
  - Otherwise: register the frame, pulse o_start_wr for that one cycle (the frame is valid in the same cycle as the pulse), increment o_frame_count (saturates at 16'hFFFF), go to GAP.
  - Advance: if slot==last, go to the next channel with slot=first; else slot+1.
  - After channel CHANNELS-1 / slot last has been evaluated (and, if printed, acknowledged), go to DONE.
- GAP: one cycle; i_wr_end ignored; then WAIT_WR.
- WAIT_WR: hold o_data_wr; on i_wr_end go to SCAN, or to DONE if the last candidate was printed.
- DONE: o_end=1; go to IDLE next cycle.
- Latency: i_start at cycle N → first o_start_wr at N+2 if the first candidate is printable.
- Empty dump: i_first_slot > i_last_slot, or mask == 0 → DONE in the cycle after start; zero frames; o_end=1.
- i_abort in any non-IDLE state (priority over all other events, including i_wr_end):
  - Next state IDLE; o_start_wr=0; o_end=1; o_aborted=1; o_data_wr and o_frame_count hold.
- i_start while busy is ignored. Simultaneous i_start and i_abort in IDLE: start wins, abort ignored.
- o_data_wr holds its last frame in IDLE.

Test Plan:
- Full dump: mask=2'b11, first=0, last=31, skip=0; i_wr_end 3 cycles after each pulse → 64 pulses; indices 0x00..0x1F then 0x20..0x3F; o_frame_count=64; o_end=1; o_aborted=0.
- Window with one channel: mask=2'b10, first=4, last=6; ch1 slot5=0xDEADBEEF, i_clk_cicle=0x2A → 3 frames; the middle frame is 56'h4D_2A_25_DEADBEEF.
- Skip zero: mask=2'b01, first=0, last=31; only slots 3 and 17 non-zero; skip=1 → exactly 2 pulses, indices 0x03 and 0x11; count=2.
- Empty cases: first=9, last=2 → o_end=1 two cycles after start, no pulse. mask=0 → same result.
- Abort: assert i_abort while in WAIT_WR after frame 5 → IDLE next cycle; o_end=1; o_aborted=1; count=5; no further pulses. A new start then clears o_end and o_aborted.
- Handshake timing: i_wr_end held high continuously → ignored in GAP; pulses spaced exactly 3 cycles apart; async reset mid-dump → all outputs 0 immediately.
